// File: rtl/sr_flip_flop.sv
// Vector of WIDTH independent clocked set/reset bits with a selectable
// resolution for S=R=1 and a registered flag that reports such conflicts.
module sr_flip_flop #(
  parameter int unsigned      WIDTH         = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned      CONFLICT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             conflict
);

  // Out-of-range policies fall back to hold.
  localparam int unsigned MODE = (CONFLICT_MODE > 3) ? 0 : CONFLICT_MODE;

  // Declaration initialisers give a defined power-up value before the first reset.
  logic [WIDTH-1:0] q_reg        = RESET_VALUE;
  logic             conflict_reg = 1'b0;
  logic [WIDTH-1:0] q_next;
  logic             conflict_next;
  logic [WIDTH-1:0] both;

  assign both = S & R;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic conflict_val;

      if (MODE == 1) begin : g_set_dom
        assign conflict_val = 1'b1;
      end else if (MODE == 2) begin : g_rst_dom
        assign conflict_val = 1'b0;
      end else if (MODE == 3) begin : g_toggle
        assign conflict_val = ~q_reg[gi];
      end else begin : g_hold
        assign conflict_val = q_reg[gi];
      end

      assign q_next[gi] = both[gi] ? conflict_val :
                          S[gi]    ? 1'b1 :
                          R[gi]    ? 1'b0 :
                                     q_reg[gi];
    end
  endgenerate

  assign conflict_next = |both;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= RESET_VALUE;
      conflict_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= conflict_next;
    end
  end

  assign Q        = q_reg;
  assign Qn       = ~q_reg;
  assign conflict = conflict_reg;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench for sr_flip_flop: four 1-bit instances (one per conflict
// mode) and a 4-bit instance, with expectations queued and checked after each edge.
module tb_sr_flip_flop;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [3:0] s1, r1, q1, qn1;
  logic [3:0] c1;
  logic [3:0] s4, r4, q4, qn4;
  logic       c4;

  int vectors     = 0;
  int miscompares = 0;
  int step        = 0;

  typedef struct {
    int         step;
    int         dut;   // 0..3: 1-bit instance of that mode, 4: 4-bit instance
    logic [3:0] q;
    logic       c;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      sr_flip_flop #(
        .WIDTH(1), .RESET_VALUE(1'b0), .CONFLICT_MODE(gi)
      ) u_dut (
        .clk(clk), .rst(rst1), .S(s1[gi]), .R(r1[gi]),
        .Q(q1[gi]), .Qn(qn1[gi]), .conflict(c1[gi])
      );
    end
  endgenerate

  sr_flip_flop #(
    .WIDTH(4), .RESET_VALUE(4'b1010), .CONFLICT_MODE(0)
  ) u_w4 (
    .clk(clk), .rst(rst4), .S(s4), .R(r4),
    .Q(q4), .Qn(qn4), .conflict(c4)
  );

  task automatic expect_out(input int dut, input logic [3:0] q, input logic c);
    exp_t e;
    e.step = step;
    e.dut  = dut;
    e.q    = q;
    e.c    = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] aq, aqn, eqn, mask;
    logic       ac;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 4) begin
        aq = q4; aqn = qn4; ac = c4; mask = 4'hf;
      end else begin
        aq = {3'b000, q1[e.dut]}; aqn = {3'b000, qn1[e.dut]}; ac = c1[e.dut]; mask = 4'h1;
      end
      eqn = ~e.q & mask;
      vectors++;
      assert (aq === e.q) else begin
        miscompares++;
        $error("FAIL step%0d dut%0d Q: got %b expected %b", e.step, e.dut, aq, e.q);
      end
      vectors++;
      assert (aqn === eqn) else begin
        miscompares++;
        $error("FAIL step%0d dut%0d Qn: got %b expected %b", e.step, e.dut, aqn, eqn);
      end
      vectors++;
      assert (ac === e.c) else begin
        miscompares++;
        $error("FAIL step%0d dut%0d conflict: got %b expected %b", e.step, e.dut, ac, e.c);
      end
      $display("step%0d dut%0d Q=%b Qn=%b conflict=%b", e.step, e.dut, aq, aqn, ac);
    end
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    drain();
    step++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    s1 = 4'b0; r1 = 4'b0; s4 = 4'b0; r4 = 4'b0;

    // Power-up value before any edge
    #1;
    for (int m = 0; m < 4; m++) expect_out(m, 4'b0, 1'b0);
    expect_out(4, 4'b1010, 1'b0);
    drain();
    step++;

    // First reset edge
    for (int m = 0; m < 4; m++) expect_out(m, 4'b0, 1'b0);
    expect_out(4, 4'b1010, 1'b0);
    edge_check();

    // Set on mode 0; load 0101 into the 4-bit instance
    @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0;
    s1 = 4'b0001; r1 = 4'b0000; s4 = 4'b0101; r4 = 4'b1010;
    expect_out(0, 4'b1, 1'b0);
    expect_out(1, 4'b0, 1'b0);
    expect_out(4, 4'b0101, 1'b0);
    edge_check();

    // Clear on mode 0; reset wins over S on the 4-bit instance
    @(negedge clk);
    s1 = 4'b0000; r1 = 4'b0001; rst4 = 1'b1; s4 = 4'b1111; r4 = 4'b0000;
    expect_out(0, 4'b0, 1'b0);
    expect_out(4, 4'b1010, 1'b0);
    edge_check();

    // Hold on mode 0; clear all bits on the 4-bit instance
    @(negedge clk);
    s1 = 4'b0000; r1 = 4'b0000; rst4 = 1'b0; s4 = 4'b0000; r4 = 4'b1111;
    expect_out(0, 4'b0, 1'b0);
    expect_out(4, 4'b0000, 1'b0);
    edge_check();

    // Conflict on every mode; mixed per-bit requests on the 4-bit instance
    @(negedge clk);
    s1 = 4'b1111; r1 = 4'b1111; s4 = 4'b0011; r4 = 4'b0110;
    expect_out(0, 4'b0, 1'b1);
    expect_out(1, 4'b1, 1'b1);
    expect_out(2, 4'b0, 1'b1);
    expect_out(3, 4'b1, 1'b1);
    expect_out(4, 4'b0001, 1'b1);
    edge_check();

    // Conflict flag drops after one cycle; second toggle in mode 3
    @(negedge clk);
    s1 = 4'b1000; r1 = 4'b1000; s4 = 4'b0000; r4 = 4'b0000;
    expect_out(0, 4'b0, 1'b0);
    expect_out(1, 4'b1, 1'b0);
    expect_out(2, 4'b0, 1'b0);
    expect_out(3, 4'b0, 1'b1);
    expect_out(4, 4'b0001, 1'b0);
    edge_check();

    // Pulses between edges must not reach the state
    @(negedge clk);
    s1 = 4'b0000; r1 = 4'b0000;
    rst4 = 1'b1; s4 = 4'b1111; rst1 = 1'b1; s1 = 4'b1111;
    #2;
    rst4 = 1'b0; s4 = 4'b0000; rst1 = 1'b0; s1 = 4'b0000;
    expect_out(0, 4'b0, 1'b0);
    expect_out(1, 4'b1, 1'b0);
    expect_out(3, 4'b0, 1'b0);
    expect_out(4, 4'b0001, 1'b0);
    edge_check();

    // Set mode-3 bit; set bit1 of the 4-bit instance
    @(negedge clk);
    s1 = 4'b1000; r1 = 4'b0000; s4 = 4'b0010; r4 = 4'b0000;
    expect_out(3, 4'b1, 1'b0);
    expect_out(4, 4'b0011, 1'b0);
    edge_check();

    // Toggle 1 -> 0 in mode 3; hold of a 1 under conflict in mode 0
    @(negedge clk);
    s1 = 4'b1000; r1 = 4'b1000; s4 = 4'b0010; r4 = 4'b0010;
    expect_out(0, 4'b0, 1'b0);
    expect_out(3, 4'b0, 1'b1);
    expect_out(4, 4'b0011, 1'b1);
    edge_check();

    // Reset with conflicting requests present, held for two edges
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst1 = 1'b1; rst4 = 1'b1;
      s1 = 4'b1111; r1 = 4'b1111; s4 = 4'b1111; r4 = 4'b1111;
      expect_out(1, 4'b0, 1'b0);
      expect_out(3, 4'b0, 1'b0);
      expect_out(4, 4'b1010, 1'b0);
      edge_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
